// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: on a cache miss, fetch the 16-byte block as eight word reads
// and stream the returned words into the cache data array. The tag/metadata
// write accompanies the final word.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic [DATA_WIDTH-1:0] memory_data,
  input  logic                  memory_data_valid,
  output logic                  fsm_busy,
  output logic                  memory_read,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic                  write_data_array,
  output logic [ADDR_WIDTH-1:0] cache_write_address,
  output logic [DATA_WIDTH-1:0] cache_write_data,
  output logic                  write_tag_array
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state, state_nxt;
  // Only the block-aligned upper bits are stored. Word offsets are
  // concatenated below them, so an offset can never carry into the block base.
  logic [ADDR_WIDTH-5:0] base_hi;
  logic [2:0]            issue_cnt;
  logic                  issue_done;
  logic [2:0]            recv_cnt;

  // State register, block base capture, and the issue/receive counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      base_hi    <= '0;
      issue_cnt  <= '0;
      issue_done <= 1'b0;
      recv_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && miss_detected) begin
        base_hi    <= miss_address[ADDR_WIDTH-1:4];
        issue_cnt  <= '0;
        issue_done <= 1'b0;
        recv_cnt   <= '0;
      end else if (state == FILL) begin
        // After the eighth request, issue_cnt stays at 7.
        // This keeps memory_address parked on the last requested word.
        if (!issue_done) begin
          if (issue_cnt == 3'd7) issue_done <= 1'b1;
          else                   issue_cnt  <= issue_cnt + 3'd1;
        end
        if (memory_data_valid) recv_cnt <= recv_cnt + 3'd1;
      end
    end
  end

  // Next state and strobes. Nothing is asserted outside FILL, so stray valids
  // in IDLE and new misses during a fill are both ignored.
  always_comb begin
    state_nxt        = state;
    memory_read      = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    case (state)
      IDLE: if (miss_detected) state_nxt = FILL;
      FILL: begin
        memory_read      = !issue_done;
        write_data_array = memory_data_valid;
        if (memory_data_valid && recv_cnt == 3'd7) begin
          write_tag_array = 1'b1;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fsm_busy            = (state == FILL);
  assign memory_address      = {base_hi, issue_cnt, 1'b0};
  assign cache_write_address = {base_hi, recv_cnt, 1'b0};
  assign cache_write_data    = memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: integer-level fill model, latency-queue memory,
// directed scenarios plus randomized traffic.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic [15:0] memory_data = '0;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy, memory_read, write_data_array, write_tag_array;
  logic [15:0] memory_address, cache_write_address, cache_write_data;

  cache_fill_fsm #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data(memory_data), .memory_data_valid(memory_data_valid),
    .fsm_busy(fsm_busy), .memory_read(memory_read), .memory_address(memory_address),
    .write_data_array(write_data_array), .cache_write_address(cache_write_address),
    .cache_write_data(cache_write_data), .write_tag_array(write_tag_array)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Behavioural model: a fill is "busy, base, requests issued, words received".
  bit          m_busy = 0;
  logic [15:0] m_base = '0;
  int          m_issued = 0;
  int          m_recv = 0;

  // Memory: in-order request queue; each entry is ready `lat` cycles after it is requested.
  typedef struct { int rdy; logic [15:0] addr; } req_t;
  req_t q[$];
  int   lat = 4;
  int   stall = 0;
  int   ret_cnt = 0;
  bit   gap_mask [0:8];
  bit   rand_gap = 0;
  bit   force_valid = 0;

  // Observed-behaviour log for the literal checks.
  int          n_wr, n_tag, n_busy, n_rd, tag_idx;
  logic [15:0] tag_addr;
  logic [15:0] rd_addr[$];
  logic [15:0] wr_addr[$];
  int          rd_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_log();
    n_wr = 0; n_tag = 0; n_busy = 0; n_rd = 0; tag_idx = -1; tag_addr = '0;
    rd_addr.delete(); wr_addr.delete(); rd_cyc.delete();
    ret_cnt = 0;
    for (int i = 0; i <= 8; i++) gap_mask[i] = 0;
  endtask

  // One clock cycle:
  // - compare at the negedge;
  // - advance the model at the posedge;
  // - drive the memory response just after the posedge.
  task automatic cycle();
    bit exp_rd, exp_wr, exp_tag;
    int off;
    @(negedge clk);
    if (!rst) begin
      m_busy = 0; m_base = '0; m_issued = 0; m_recv = 0;
      check("rst_busy", fsm_busy, 0);
      check("rst_read", memory_read, 0);
      check("rst_maddr", memory_address, 0);
      check("rst_wr", write_data_array, 0);
      check("rst_tag", write_tag_array, 0);
      check("rst_caddr", cache_write_address, 0);
    end else begin
      exp_rd  = m_busy && m_issued < 8;
      exp_wr  = m_busy && memory_data_valid;
      exp_tag = exp_wr && m_recv == 7;
      check("busy", fsm_busy, m_busy);
      check("memory_read", memory_read, exp_rd);
      check("write_data_array", write_data_array, exp_wr);
      check("write_tag_array", write_tag_array, exp_tag);
      if (m_busy) begin
        off = (m_issued < 8) ? m_issued : 7;
        check("memory_address", memory_address, m_base + 16'(2 * off));
      end
      if (exp_wr) begin
        check("cache_write_address", cache_write_address, m_base + 16'(2 * m_recv));
        check("cache_write_data", cache_write_data, memory_data);
      end
    end
    if (fsm_busy) n_busy++;
    if (memory_read) begin
      n_rd++; rd_addr.push_back(memory_address); rd_cyc.push_back(cyc);
      q.push_back('{rdy: cyc + lat, addr: memory_address});
    end
    if (write_data_array) begin
      n_wr++; wr_addr.push_back(cache_write_address);
    end
    if (write_tag_array) begin
      n_tag++; tag_idx = n_wr; tag_addr = cache_write_address;
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      if (!m_busy) begin
        if (miss_detected) begin
          m_busy = 1; m_base = miss_address & 16'hFFF0; m_issued = 0; m_recv = 0;
        end
      end else begin
        if (m_issued < 8) m_issued++;
        if (memory_data_valid) begin
          m_recv++;
          if (m_recv == 8) m_busy = 0;
        end
      end
    end
    #1;
    memory_data_valid = 1'b0;
    if (force_valid) begin
      memory_data_valid = 1'b1;
      memory_data = 16'($urandom);
    end else if (stall > 0) begin
      stall--;
    end else if (q.size() > 0 && q[0].rdy <= cyc) begin
      void'(q.pop_front());
      memory_data_valid = 1'b1;
      memory_data = 16'($urandom);
      ret_cnt++;
      if (ret_cnt <= 8 && gap_mask[ret_cnt]) stall = 1;
      if (rand_gap && ($urandom % 4 == 0)) stall = 1 + ($urandom % 2);
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    int k;
    clear_log();

    // Reset, then idle with no miss.
    rst = 1'b0;
    run(3);
    rst = 1'b1;
    run(4);
    check("idle_busy_cycles", n_busy, 0);
    check("idle_writes", n_wr, 0);

    // Single fill at 3A57 with 4-cycle memory latency.
    clear_log();
    miss_address = 16'h3A57; miss_detected = 1'b1;
    cycle();
    miss_detected = 1'b0; miss_address = 16'h0000;
    run(20);
    check("single_reads", n_rd, 8);
    check("single_rd0", rd_addr[0], 16'h3A50);
    check("single_rd7", rd_addr[7], 16'h3A5E);
    check("single_writes", n_wr, 8);
    check("single_wr0", wr_addr[0], 16'h3A50);
    check("single_wr7", wr_addr[7], 16'h3A5E);
    check("single_tag_addr", tag_addr, 16'h3A5E);
    check("single_tags", n_tag, 1);
    check("single_busy", n_busy, 12);

    // Gapped returns: one bubble after words 2 and 5.
    clear_log();
    gap_mask[2] = 1; gap_mask[5] = 1;
    miss_address = 16'h1234; miss_detected = 1'b1;
    cycle();
    miss_detected = 1'b0;
    run(24);
    check("gap_writes", n_wr, 8);
    check("gap_wr4", wr_addr[4], 16'h1238);
    check("gap_tags", n_tag, 1);
    check("gap_tag_on_8th", tag_idx, 8);
    check("gap_busy", n_busy, 14);

    // Miss held through the fill, with the address switched mid-fill.
    clear_log();
    miss_address = 16'h3A57; miss_detected = 1'b1;
    run(4);
    miss_address = 16'hFFF0;
    run(10);
    miss_detected = 1'b0;
    run(20);
    check("mdf_writes", n_wr, 16);
    check("mdf_tags", n_tag, 2);
    check("mdf_wr7", wr_addr[7], 16'h3A5E);
    check("mdf_wr8", wr_addr[8], 16'hFFF0);
    check("mdf_wr15", wr_addr[15], 16'hFFFE);
    check("mdf_rd15", rd_addr[15], 16'hFFFE);
    check("mdf_restart_gap", rd_cyc[8] - rd_cyc[7], 6);
    check("mdf_busy", n_busy, 24);

    // Reset after the third write while memory keeps returning data.
    clear_log();
    miss_address = 16'h3A57; miss_detected = 1'b1;
    cycle();
    miss_detected = 1'b0;
    k = 0;
    while (n_wr < 3 && k < 50) begin cycle(); k++; end
    check("rstmid_reached_3", n_wr, 3);
    rst = 1'b0;
    run(2);
    rst = 1'b1;
    run(15);
    check("rstmid_writes", n_wr, 3);
    check("rstmid_tags", n_tag, 0);
    check("rstmid_busy", fsm_busy, 0);
    check("rstmid_queue_drained", q.size(), 0);

    // Stray valids while idle.
    clear_log();
    force_valid = 1'b1;
    run(5);
    force_valid = 1'b0;
    run(1);
    check("stray_writes", n_wr, 0);
    check("stray_tags", n_tag, 0);
    check("stray_busy", n_busy, 0);

    // Randomized traffic: misses, address churn, bubbles, varying latency.
    clear_log();
    rand_gap = 1'b1;
    for (int seg = 0; seg < 8; seg++) begin
      k = 0;
      while (q.size() > 0 && k < 100) begin cycle(); k++; end
      lat = 1 + int'($urandom % 6);
      for (int c = 0; c < 120; c++) begin
        miss_detected = ($urandom % 3 == 0);
        miss_address  = 16'($urandom);
        cycle();
      end
    end
    miss_detected = 1'b0;
    run(60);
    check("rand_idle_at_end", fsm_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
